// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway BLE authorization block.
package segway_pkg;

    localparam int unsigned BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;

    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle rx_rdy strobe.
module uart_rx
    import segway_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy
);

    localparam int unsigned   CW       = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2);

    rx_state_t     state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    data_q;
    logic          rdy_q;
    logic          fall;
    logic          expire;

    assign fall   = rx_prev_q & ~rx_sync_q;
    // Expiry is the last cycle of a count, so reloading N spaces samples exactly N clocks apart.
    assign expire = (cnt_q <= CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rdy_q     <= 1'b0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        cnt_q   <= HALF_CNT;
                    end
                end
                START: begin
                    if (expire) begin
                        if (!rx_sync_q) begin
                            state_q <= DATA;
                            cnt_q   <= FULL_CNT;
                            bit_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (expire) begin
                        data_q <= {rx_sync_q, data_q[7:1]};
                        cnt_q  <= FULL_CNT;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (expire) begin
                        rdy_q <= rx_sync_q;
                        // A start edge landing in the exit cycle must not be lost.
                        if (fall) begin
                            state_q <= START;
                            cnt_q   <= HALF_CNT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = data_q;
    assign rx_rdy  = rdy_q;

endmodule

// File: rtl/auth_blk.sv
// Segway power authorization: BLE 'g'/'s' commands gated by the rider-present load cells.
module auth_blk
    import segway_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    input  logic rider_off,
    output logic pwr_up
);

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        go_cmd;
    logic        stop_cmd;
    auth_state_t state_q;
    logic        pwr_up_q;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy)
    );

    assign go_cmd   = rx_rdy && (rx_data == CMD_GO);
    assign stop_cmd = rx_rdy && (rx_data == CMD_STOP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OFF;
            pwr_up_q <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    if (go_cmd) begin
                        state_q  <= PWR1;
                        pwr_up_q <= 1'b1;
                    end
                end
                PWR1: begin
                    if (stop_cmd) begin
                        state_q  <= rider_off ? OFF : PWR2;
                        pwr_up_q <= ~rider_off;
                    end
                end
                PWR2: begin
                    // Rider leaving wins over a simultaneous 'g'.
                    if (rider_off) begin
                        state_q  <= OFF;
                        pwr_up_q <= 1'b0;
                    end else if (go_cmd) begin
                        state_q  <= PWR1;
                        pwr_up_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= OFF;
                    pwr_up_q <= 1'b0;
                end
            endcase
        end
    end

    assign pwr_up = pwr_up_q;

endmodule

// File: tb/tb_auth_blk.sv
// Self-checking bench for auth_blk: fast instance vs. frame-level model, plus one default-baud instance.
`timescale 1ns/1ps
module tb_auth_blk;

    localparam int unsigned N    = 16;
    localparam int unsigned NDEF = 2604;

    logic clk = 1'b0;
    logic rst_n, RX, rider_off, pwr_up;
    logic rst_n_slow, rx_slow, rider_slow, pwr_slow;

    always #5 clk = ~clk;

    auth_blk #(.BAUD_DIV(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rider_off (rider_off),
        .pwr_up    (pwr_up)
    );

    auth_blk dut_slow (
        .clk       (clk),
        .rst_n     (rst_n_slow),
        .RX        (rx_slow),
        .rider_off (rider_slow),
        .pwr_up    (pwr_slow)
    );

    int unsigned     errors = 0;
    int unsigned     checks = 0;
    longint unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: 0 = OFF, 1 = PWR1, 2 = PWR2.
    int              m_state = 0;
    int              m_next  = 0;
    bit              pend    = 1'b0;
    bit              chk_en  = 1'b0;
    longint unsigned win_lo  = 0;
    longint unsigned win_hi  = 0;

    function automatic int auth_next(input int s, input logic [7:0] b, input bit stop_ok, input logic roff);
        if (!stop_ok) return s;
        case (s)
            0:       return (b == 8'h67) ? 1 : 0;
            1:       return (b == 8'h73) ? (roff ? 0 : 2) : 1;
            default: return roff ? 0 : ((b == 8'h67) ? 1 : 2);
        endcase
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: pwr_up=%b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Outside a frame's decision window pwr_up must match the model exactly; inside it, old or new.
    always @(negedge clk) begin
        if (chk_en) begin
            if (pend && cyc >= win_lo && cyc <= win_hi) begin
                checks++;
                if (pwr_up !== logic'(m_state != 0) && pwr_up !== logic'(m_next != 0)) begin
                    errors++;
                    $display("FAIL window: pwr_up=%b expected %b or %b at cycle %0d",
                             pwr_up, m_state != 0, m_next != 0, cyc);
                end
            end else begin
                check("model", pwr_up, logic'(((pend && cyc > win_hi) ? m_next : m_state) != 0));
            end
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rider(input logic v);
        rider_off = v;
        @(posedge clk);
        if (v && m_state == 2) m_state = 0;
        #1;
    endtask

    // rst_bit >= 0 pulses rst_n for one cycle two clocks into that bit slot.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int rst_bit);
        logic [9:0] f;
        f      = {stop_ok, b, 1'b0};
        m_next = auth_next(m_state, b, stop_ok, rider_off);
        win_lo = cyc + 9 * N;
        win_hi = cyc + (19 * N) / 2 + 5;
        pend   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            if (i == rst_bit) begin
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                pend    = 1'b0;
                m_state = 0;
                #1 rst_n = 1'b1;
                repeat (N - 3) @(posedge clk);
                #1;
            end else begin
                repeat (N) @(posedge clk);
                #1;
            end
        end
        RX = 1'b1;
        if (pend) m_state = m_next;
        pend = 1'b0;
    endtask

    task automatic glitch(input int unsigned len);
        RX = 1'b0;
        repeat (len) @(posedge clk);
        #1 RX = 1'b1;
    endtask

    task automatic run_main();
        logic [7:0] b;
        int         r;
        rst_n     = 1'b0;
        RX        = 1'b1;
        rider_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", pwr_up, 1'b0);
        rst_n = 1'b1;
        idle(4);
        chk_en = 1'b1;

        send_frame(8'h67, 1'b1, -1);
        check("go_from_off", pwr_up, 1'b1);

        send_frame(8'h73, 1'b1, -1);
        check("stop_rider_on", pwr_up, 1'b1);
        set_rider(1'b1);
        check("rider_off_pwr2", pwr_up, 1'b0);

        send_frame(8'h67, 1'b1, -1);
        check("go_rider_off", pwr_up, 1'b1);
        send_frame(8'h73, 1'b1, -1);
        check("stop_rider_off", pwr_up, 1'b0);
        set_rider(1'b0);

        send_frame(8'h41, 1'b1, -1);
        send_frame(8'h73, 1'b1, -1);
        send_frame(8'h67, 1'b0, -1);
        check("off_ignored", pwr_up, 1'b0);
        idle(2 * N);

        glitch((3 * N) / 10);
        idle(2 * N);
        check("glitch_ignored", pwr_up, 1'b0);
        send_frame(8'h67, 1'b1, -1);
        check("go_after_glitch", pwr_up, 1'b1);

        send_frame(8'h73, 1'b1, -1);
        send_frame(8'h67, 1'b1, -1);
        send_frame(8'h41, 1'b1, -1);
        send_frame(8'h73, 1'b1, -1);
        check("b2b_pwr2", pwr_up, 1'b1);
        send_frame(8'h67, 1'b1, -1);
        check("b2b_pwr1", pwr_up, 1'b1);

        send_frame(8'h67, 1'b1, 4);
        check("reset_midframe", pwr_up, 1'b0);
        idle(12 * N);
        check("partial_dropped", pwr_up, 1'b0);
        send_frame(8'h67, 1'b1, -1);
        check("go_after_reset", pwr_up, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = (r < 4) ? 8'h67 : ((r < 8) ? 8'h73 : 8'($urandom));
            send_frame(b, $urandom_range(0, 9) != 0, -1);
            if ($urandom_range(0, 3) == 0) set_rider(~rider_off);
            idle($urandom_range(0, 2 * N));
        end
        idle(2 * N);
    endtask

    task automatic run_slow();
        logic [9:0] f;
        bit         seen;
        f          = {1'b1, 8'h67, 1'b0};
        seen       = 1'b0;
        rx_slow    = 1'b1;
        rider_slow = 1'b0;
        rst_n_slow = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n_slow = 1'b1;
        idle(20);
        check("slow_reset", pwr_slow, 1'b0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rx_slow = f[i];
                    repeat (NDEF) @(posedge clk);
                    #1;
                end
                rx_slow = 1'b1;
            end
            begin
                repeat (9 * NDEF) @(posedge clk);
                #1;
                check("slow_not_early", pwr_slow, 1'b0);
                for (int k = 0; k < NDEF && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (pwr_slow === 1'b1) seen = 1'b1;
                end
                check("slow_within_10_bits", seen, 1'b1);
            end
        join
        idle(10);
        check("slow_hold", pwr_slow, 1'b1);
    endtask

    initial begin
        fork
            run_main();
            run_slow();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/auth_blk.md
AUTH_BLK -- requirements
Module: auth_blk

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 2604, meaning clk cycles per UART bit (19200 baud at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port RX, input, 1, asynchronous UART serial line from the BLE module, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rider_off, input, 1, high when the load cells report no rider present.
REQ-006 The block SHALL have port pwr_up, output, 1, high when the Segway is authorized to balance/drive.

Function
REQ-007 RX SHALL pass through two flops before any use; a start bit is a high-to-low transition on the synchronized signal.
REQ-008 The receiver SHALL have states IDLE, START, DATA, STOP.
REQ-009 IDLE: on falling edge of synchronized RX -> START; baud counter loads BAUD_DIV/2.
REQ-010 START: at count expiry, if RX low -> DATA with counter = BAUD_DIV; if RX high (glitch) -> IDLE, no byte produced.
REQ-011 DATA: sample RX at each counter expiry, shift into rx_data MSB-first-in so bit0 ends in LSB; after the 8th sample -> STOP.
REQ-012 STOP: at counter expiry, RX high -> rx_rdy pulses 1 cycle with rx_data valid; RX low (framing error) -> byte discarded; either case -> IDLE.
REQ-013 Baud counter SHALL be wide enough for BAUD_DIV (12 bits at default) and SHALL count down without wrap past 0.
REQ-014 Latency: rx_rdy SHALL assert within 9.5 bit times + 4 clk cycles of the start-bit falling edge on RX.
REQ-015 The auth state machine SHALL have states OFF, PWR1, PWR2; pwr_up = 1 in PWR1 and PWR2, 0 in OFF; pwr_up is registered.
REQ-016 OFF: rx_rdy with byte 0x67 ('g') -> PWR1.
REQ-017 PWR1: rx_rdy with 0x73 ('s') and rider_off=1 -> OFF; 0x73 with rider_off=0 -> PWR2.
REQ-018 PWR2: rider_off=1 -> OFF; rx_rdy with 0x67 -> PWR1; rider_off takes priority if both occur in the same cycle.
REQ-019 Any other byte value SHALL be consumed and ignored in every state; 'g' in PWR1 and 's' in PWR2/OFF SHALL cause no change.
REQ-020 pwr_up SHALL change exactly one cycle after the qualifying rx_rdy or rider_off cycle.
REQ-021 Back-to-back bytes with one stop bit SHALL all be received; a start edge sampled in the STOP-exit cycle SHALL still be detected.

Reset
REQ-022 With rst_n low at a clk edge: receiver -> IDLE, counters 0, rx_data 0, rx_rdy 0, sync flops 1, auth -> OFF, pwr_up 0.
REQ-023 Reset mid-frame SHALL abandon the partial byte; the next byte SHALL be received correctly after release.

Structure
REQ-024 Package segway_pkg SHALL hold auth_state_t (OFF, PWR1, PWR2), rx_state_t, CMD_GO = 8'h67, CMD_STOP = 8'h73, and the default BAUD_DIV.
REQ-025 The receiver SHALL be sub-module uart_rx (clk, rst_n, RX, rx_data, rx_rdy); auth_blk instantiates it and holds only the auth state machine.

Verification
REQ-026 Drive 'g' (0x67) with the standard UART transmitter at BAUD_DIV=2604 -> pwr_up 0->1 within 10 bit times of the start bit.
REQ-027 From PWR1, rider_off=0, send 's' -> pwr_up stays 1 (PWR2); then raise rider_off -> pwr_up 0 on the next cycle.
REQ-028 From PWR1, rider_off=1, send 's' -> pwr_up 0 one cycle after rx_rdy.
REQ-029 From OFF, send 0x41, 0x73, and a 0x67 frame with a low stop bit -> pwr_up stays 0 throughout.
REQ-030 Apply a 0.3-bit-time low glitch on RX in IDLE -> no rx_rdy; a following valid 'g' -> pwr_up 1.
REQ-031 Assert rst_n low for 1 cycle during bit 4 of a 'g' frame -> pwr_up 0; the next full 'g' -> pwr_up 1.
